// File: rtl/anubis_pkg.sv
// Shared definitions for the Anubis round controller and its gamma layer.
package anubis_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY0  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  function automatic int R_OF(input int n);
    return 8 + n;
  endfunction

endpackage

// File: rtl/anubis_gamma.sv
// Gamma layer: sixteen parallel 8-bit S-boxes built from the P/Q 4-bit mini-boxes.
module anubis_gamma
  import anubis_pkg::*;
(
  input  logic [BLOCK_W-1:0] data_in,
  output logic [BLOCK_W-1:0] data_out
);

  localparam logic [63:0] P_TBL = 64'h3FE054BCDA967821;
  localparam logic [63:0] Q_TBL = 64'h9E56A23CF04D7B18;

  function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] x);
    return tbl[(15 - int'(x)) * 4 +: 4];
  endfunction

  // Outer bit swizzle is its own inverse, so the whole S-box stays an involution.
  function automatic logic [7:0] swz(input logic [7:0] x);
    return {x[7:5], x[2], x[0], x[4], x[1], x[3]};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [3:0] a;
    logic [3:0] b;
    t = swz(x);
    a = nib(P_TBL, t[7:4]);
    b = nib(Q_TBL, t[3:0]);
    t = {a[3:2], b[3:2], a[1:0], b[1:0]};
    a = nib(Q_TBL, t[7:4]);
    b = nib(P_TBL, t[3:0]);
    t = {a[3:2], b[3:2], a[1:0], b[1:0]};
    a = nib(P_TBL, t[7:4]);
    b = nib(Q_TBL, t[3:0]);
    return swz({a, b});
  endfunction

  always_comb begin
    data_out = '0;
    for (int i = 0; i < BLOCK_W / 8; i++) begin
      data_out[8*i +: 8] = sbox(data_in[8*i +: 8]);
    end
  end

endmodule

// File: rtl/anubis_round_ctrl.sv
// Iterative Anubis round sequencer: one round per acked round key.
//   state | meaning
//   IDLE  | waiting for a plaintext block
//   KEY0  | whitening with round key 0
//   ROUND | gamma + external pi/theta + key add, rounds 1..R
//   DONE  | result held on out_data until out_ready
module anubis_round_ctrl
  import anubis_pkg::*;
#(
  parameter int N_KEY = 4,
  parameter int RND_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               key_req,
  output logic [RND_W-1:0]   key_idx,
  input  logic               key_ack,
  input  logic [BLOCK_W-1:0] key_in,
  output logic [BLOCK_W-1:0] lin_in,
  output logic               lin_last,
  input  logic [BLOCK_W-1:0] lin_out,
  output logic               busy
);

  localparam int R = R_OF(N_KEY);
  localparam logic [RND_W-1:0] R_IDX = RND_W'(R);

  fsm_t               state;
  logic [RND_W-1:0]   rnd;
  logic [BLOCK_W-1:0] st;
  logic [BLOCK_W-1:0] g_out;

  anubis_gamma u_gamma (
    .data_in  (st),
    .data_out (g_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= '0;
      st    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= in_data;
            rnd   <= '0;
            state <= KEY0;
          end
        end
        KEY0: begin
          if (key_ack) begin
            st    <= st ^ key_in;
            rnd   <= RND_W'(1);
            state <= ROUND;
          end
        end
        ROUND: begin
          if (key_ack) begin
            st <= lin_out ^ key_in;
            if (rnd == R_IDX) state <= DONE;
            else              rnd   <= rnd + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All handshake outputs decode the state register only; no path from key_ack.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign key_req   = (state == KEY0) || (state == ROUND);
  assign key_idx   = (state == ROUND) ? rnd : '0;
  assign lin_in    = (state == ROUND) ? g_out : '0;
  assign lin_last  = (state == ROUND) && (rnd == R_IDX);
  assign out_data  = st;

endmodule

// File: tb/tb_anubis_round_ctrl.sv
// Self-checking bench for anubis_round_ctrl with an ack-counting reference model.
module tb_anubis_round_ctrl;

  localparam int R4 = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         key_req;
  logic [4:0]   key_idx;
  logic         key_ack = 1'b1;
  logic [127:0] key_in;
  logic [127:0] lin_in;
  logic         lin_last;
  logic [127:0] lin_out;
  logic         busy;

  logic         in_valid5 = 1'b0;
  logic         in_ready5;
  logic         out_valid5;
  logic [127:0] out_data5;
  logic         key_req5;
  logic [4:0]   key_idx5;
  logic [127:0] lin_in5;
  logic         lin_last5;
  logic         busy5;

  logic key_mode = 1'b0;
  logic ack3 = 1'b0;
  int   scnt = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign key_in  = key_mode ? {16{3'b000, key_idx}} : '0;
  assign lin_out = lin_in;

  anubis_round_ctrl #(.N_KEY(4), .RND_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_req(key_req), .key_idx(key_idx), .key_ack(key_ack), .key_in(key_in),
    .lin_in(lin_in), .lin_last(lin_last), .lin_out(lin_out), .busy(busy));

  anubis_round_ctrl #(.N_KEY(5), .RND_W(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(128'd0),
    .out_valid(out_valid5), .out_ready(1'b1), .out_data(out_data5),
    .key_req(key_req5), .key_idx(key_idx5), .key_ack(1'b1), .key_in(128'd0),
    .lin_in(lin_in5), .lin_last(lin_last5), .lin_out(lin_in5), .busy(busy5));

  // Reference S-box from the P/Q mini-boxes
  logic [3:0] pb [16] = '{4'h3,4'hF,4'hE,4'h0,4'h5,4'h4,4'hB,4'hC,4'hD,4'hA,4'h9,4'h6,4'h7,4'h8,4'h2,4'h1};
  logic [3:0] qb [16] = '{4'h9,4'hE,4'h5,4'h6,4'hA,4'h2,4'h3,4'hC,4'hF,4'h0,4'h4,4'hD,4'h7,4'hB,4'h1,4'h8};

  function automatic logic [7:0] bs(input logic [7:0] x);
    logic [7:0] v;
    logic [3:0] h;
    logic [3:0] l;
    v = {x[7:5], x[2], x[0], x[4], x[1], x[3]};
    for (int layer = 0; layer < 3; layer++) begin
      h = (layer == 1) ? qb[v[7:4]] : pb[v[7:4]];
      l = (layer == 1) ? pb[v[3:0]] : qb[v[3:0]];
      v = (layer == 2) ? {h, l} : {h[3:2], l[3:2], h[1:0], l[1:0]};
    end
    return {v[7:5], v[2], v[0], v[4], v[1], v[3]};
  endfunction

  function automatic logic [127:0] gam(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = bs(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] kexp(input int k);
    logic [7:0] b;
    b = 8'(k);
    return key_mode ? {16{b}} : '0;
  endfunction

  // Model: a block needs R+1 acked keys, then waits for out_ready.
  logic         m_act, m_pend;
  int           m_need;
  logic [127:0] m_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_pend <= 1'b0; m_need <= 0; m_s <= '0;
    end else if (!m_act) begin
      if (in_valid) begin
        m_act <= 1'b1; m_need <= R4 + 1; m_s <= in_data;
      end
    end else if (m_need > 0) begin
      if (key_ack) begin
        if (m_need == R4 + 1) m_s <= m_s ^ kexp(0);
        else                  m_s <= gam(m_s) ^ kexp(R4 + 1 - m_need);
        m_need <= m_need - 1;
        if (m_need == 1) m_pend <= 1'b1;
      end
    end else if (out_ready) begin
      m_act <= 1'b0; m_pend <= 1'b0;
    end
  end

  int           seen [32];
  int           last_cnt, last_bad, stall_cnt;
  logic         stalled = 1'b0;
  logic [127:0] stall_s;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare();
    int idx;
    chk("in_ready", 128'(in_ready), 128'(!m_act));
    chk("busy", 128'(busy), 128'(m_act));
    chk("out_valid", 128'(out_valid), 128'(m_pend));
    chk("key_req", 128'(key_req), 128'(m_act && m_need > 0));
    chk("out_data", out_data, m_s);
    if (m_act && m_need > 0) begin
      idx = R4 + 1 - m_need;
      chk("key_idx", 128'(key_idx), 128'(idx));
      chk("lin_last", 128'(lin_last), 128'(idx == R4));
      chk("lin_in", lin_in, (idx > 0) ? gam(m_s) : 128'd0);
    end else begin
      chk("lin_in_idle", lin_in, 128'd0);
      chk("lin_last_idle", 128'(lin_last), 128'd0);
    end
    if (stalled) chk("stall_hold", out_data, stall_s);
    stalled = key_req && !key_ack;
    stall_s = m_s;
    if (stalled) stall_cnt++;
    if (key_req && key_ack) begin
      seen[key_idx]++;
      if (lin_last) begin
        last_cnt++;
        if (key_idx != 5'd12) last_bad++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) compare();
    else stalled = 1'b0;
    @(posedge clk);
    #2;
    key_ack = !ack3 || (scnt % 3 == 0);
    scnt++;
  endtask

  task automatic run_block(input logic [127:0] d, input int budget, output int lat);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < budget) begin
      step();
      lat++;
    end
    chk("out_valid_timeout", 128'(out_valid), 128'd1);
  endtask

  initial begin
    int lat, bad, n, na;
    int acc [8];

    bad = 0;
    for (int i = 0; i < 256; i++) if (bs(bs(8'(i))) != 8'(i)) bad++;
    chk("model_sbox_00", 128'(bs(8'h00)), 128'h A7);
    chk("model_sbox_a7", 128'(bs(8'hA7)), 128'h00);
    chk("model_sbox_invol", 128'(bad), 128'd0);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_key_req", 128'(key_req), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst5_in_ready", 128'(in_ready5), 128'd1);
    @(posedge clk); #2;

    // Zero block, zero keys: even number of involutive gamma passes returns zero
    run_block(128'd0, 40, lat);
    chk("lat_r12", 128'(lat), 128'(R4 + 2));
    chk("zero_r12", out_data, 128'd0);
    step();

    // N_KEY=5: thirteen passes leave S(00) in every byte
    in_valid5 = 1'b1;
    step();
    in_valid5 = 1'b0;
    lat = 1;
    while (!out_valid5 && lat < 40) begin step(); lat++; end
    chk("lat_r13", 128'(lat), 128'd15);
    chk("zero_r13", out_data5, {16{8'hA7}});
    step();

    // Sparse key_ack: every third cycle
    foreach (seen[i]) seen[i] = 0;
    stall_cnt = 0;
    ack3 = 1'b1; scnt = 0;
    run_block(128'd0, 80, lat);
    chk("zero_stalled", out_data, 128'd0);
    bad = 0;
    for (int k = 0; k < 32; k++) if (seen[k] != ((k <= R4) ? 1 : 0)) bad++;
    chk("key_idx_once", 128'(bad), 128'd0);
    chk("stalls_seen", 128'(stall_cnt >= 24), 128'd1);
    ack3 = 1'b0; key_ack = 1'b1;
    step();

    // Index-dependent keys
    key_mode = 1'b1;
    last_cnt = 0; last_bad = 0;
    run_block(128'd0, 40, lat);
    chk("lat_keys", 128'(lat), 128'(R4 + 2));
    chk("lin_last_once", 128'(last_cnt), 128'd1);
    chk("lin_last_idx12", 128'(last_bad), 128'd0);
    step();

    // Hold in DONE with out_ready low
    out_ready = 1'b0;
    run_block(128'h0123456789ABCDEF_FEDCBA9876543210, 40, lat);
    stall_s = m_s;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 128'(out_valid), 128'd1);
      chk("hold_data", out_data, stall_s);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
      in_valid = (i == 4);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_in_ready", 128'(in_ready), 128'd1);
    chk("release_out_valid", 128'(out_valid), 128'd0);

    // Reset in the middle of round 6
    in_data = 128'h55AA_1234_0000_FFFF_0F0F_F0F0_9999_6666;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!(key_req && key_idx == 5'd6) && n < 40) begin step(); n++; end
    chk("reach_round6", 128'(key_req && key_idx == 5'd6), 128'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_key_req", 128'(key_req), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    step();
    run_block(128'hDEADBEEF_00112233_44556677_8899AABB, 40, lat);
    chk("lat_after_rst", 128'(lat), 128'(R4 + 2));
    step();

    // Back-to-back blocks with out_ready high
    in_valid = 1'b1;
    na = 0;
    for (int t = 0; t < 50; t++) begin
      if (in_ready && na < 8) begin acc[na] = t; na++; end
      in_data = {4{32'(t)}};
      step();
    end
    in_valid = 1'b0;
    chk("accept_count", 128'(na), 128'd4);
    for (int i = 1; i < na && i < 8; i++) chk("accept_period", 128'(acc[i] - acc[i-1]), 128'(R4 + 3));
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    chk("drain_idle", 128'(busy), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
